// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and the fetch FSM state type.
//   INSTR_W  instruction / PC width
//   PC_RESET text-segment base loaded into the PC on reset
//   PC_STEP  byte distance between consecutive instructions
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam logic [31:0] PC_RESET = 32'h0040_0000;
   localparam logic [31:0] PC_STEP = 32'd4;
   typedef enum logic [1:0] {IDLE, FETCH, VALID} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// pc_register: program counter with synchronous reset, load and increment.
//   clk, reset   clock and synchronous active-high reset (pc <= RESET_VAL)
//   load         load load_val (wins over inc)
//   load_val     value to load
//   inc          advance pc by PC_STEP
//   pc           current program counter
module pc_register #(
   parameter int WIDTH = mips_pkg::INSTR_W,
   parameter logic [WIDTH-1:0] RESET_VAL = mips_pkg::PC_RESET
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] pc
);
   import mips_pkg::*;
   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_VAL;
      else if (load) pc <= load_val;
      else if (inc) pc <= pc + WIDTH'(PC_STEP);
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage - PC, ROM req/valid handshake, IR with decode handshake.
//   clk, reset               clock and synchronous active-high reset
//   fetch_en                 control requests the next instruction
//   rom_req, rom_addr        ROM read request and word address (pc - PC_RESET) >> 2
//   rom_data, rom_valid      ROM read response
//   instr_out, instr_valid   IR contents and unconsumed-instruction flag
//   instr_ready              decode accepts instr_out
//   redirect, redirect_pc    branch/jump target load
//   pc_out, pc_plus4         address of IR instruction and that address + 4
//   align_err                one-cycle pulse after a misaligned redirect target
//   range_err                fetch address beyond the ROM window while requesting
module instr_fetch_unit #(
   parameter int DATA_WIDTH = mips_pkg::INSTR_W,
   parameter logic [DATA_WIDTH-1:0] PC_RESET = mips_pkg::PC_RESET,
   parameter int ROM_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en,
   output logic                  rom_req,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  rom_valid,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  align_err,
   output logic                  range_err
);
   import mips_pkg::*;
   fetch_state_t state, next;
   logic [DATA_WIDTH-1:0] pc, word;
   logic capture;
   pc_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(PC_RESET)) u_pc (
      .clk(clk),
      .reset(reset),
      .load(redirect),
      .load_val({redirect_pc[DATA_WIDTH-1:2], 2'b00}),
      .inc(capture),
      .pc(pc)
   );
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= next;
   end
   // A redirect discards any word returning in the same cycle and squashes a held IR.
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = fetch_en ? FETCH : IDLE;
         FETCH:   next = (rom_valid && !redirect) ? VALID : FETCH;
         VALID:   next = (redirect || instr_ready) ? (fetch_en ? FETCH : IDLE) : VALID;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      rom_req = state == FETCH;
      instr_valid = state == VALID;
      capture = rom_req && rom_valid && !redirect;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_out <= '0;
         pc_out <= PC_RESET;
         align_err <= 1'b0;
      end else begin
         align_err <= redirect && |redirect_pc[1:0];
         if (capture) begin
            instr_out <= rom_data;
            pc_out <= pc;
         end
      end
   end
   // Word offset from the text base; wraps below PC_RESET so those PCs read as out of range.
   assign word = (pc - PC_RESET) >> 2;
   assign rom_addr = word[ROM_ADDR_W-1:0];
   assign range_err = rom_req && ((word >> ROM_ADDR_W) != '0);
   assign pc_plus4 = pc_out + DATA_WIDTH'(PC_STEP);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic against a scoreboard.
module tb_instr_fetch_unit;
   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int DEPTH = 256;
   logic clk = 0, reset, fetch_en, rom_req, rom_valid, instr_valid, instr_ready;
   logic redirect, align_err, range_err;
   logic [7:0] rom_addr;
   logic [31:0] rom_data, instr_out, redirect_pc, pc_out, pc_plus4;
   int vectors = 0, errors = 0;
   logic mon_on = 0, prev_al = 0;
   typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
   typedef struct {logic [7:0] a; logic r;} addr_t;
   exp_t exp_q[$];
   addr_t addr_q[$];
   logic [31:0] rom_mem[DEPTH];
   logic [31:0] model_pc;
   exp_t e;
   addr_t ea;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .rom_req(rom_req), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_valid(rom_valid), .instr_out(instr_out),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .pc_out(pc_out), .pc_plus4(pc_plus4),
      .align_err(align_err), .range_err(range_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_empty(input string name);
      vectors++;
      errors++;
      $display("FAIL %s: DUT output with empty scoreboard", name);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard monitor: looks at each cycle mid-period, when inputs and outputs are stable.
   always @(negedge clk) begin
      if (mon_on) begin
         check("align_err", {31'd0, align_err}, {31'd0, prev_al});
         if (rom_req) begin
            if (addr_q.size() == 0) fail_empty("rom_addr");
            else begin
               ea = addr_q.pop_front();
               check("rom_addr", {24'd0, rom_addr}, {24'd0, ea.a});
               check("range_err", {31'd0, range_err}, {31'd0, ea.r});
            end
         end else check("range_err_idle", {31'd0, range_err}, 32'd0);
         if (instr_valid && (redirect || instr_ready)) begin
            if (exp_q.size() == 0) fail_empty("instr");
            else begin
               e = exp_q.pop_front();
               if (!redirect) begin
                  check("instr_out", instr_out, e.instr);
                  check("pc_out", pc_out, e.pc);
                  check("pc_plus4", pc_plus4, e.pc + 32'd4);
               end
            end
         end
      end
      prev_al = redirect && (redirect_pc[1:0] != 2'b00);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] off;
      logic rq;
      int r;
      foreach (rom_mem[i]) rom_mem[i] = $urandom;
      reset = 1; fetch_en = 0; rom_valid = 0; rom_data = 0; instr_ready = 0;
      redirect = 0; redirect_pc = 0;
      // T1 reset
      step(); step();
      check("t1_pc_out", pc_out, BASE);
      check("t1_pc_plus4", pc_plus4, BASE + 4);
      check("t1_rom_req", {31'd0, rom_req}, 0);
      check("t1_instr_valid", {31'd0, instr_valid}, 0);
      check("t1_instr_out", instr_out, 0);
      check("t1_rom_addr", {24'd0, rom_addr}, 0);
      reset = 0;
      // T2 first fetch
      fetch_en = 1; step();
      check("t2_rom_req", {31'd0, rom_req}, 1);
      check("t2_rom_addr", {24'd0, rom_addr}, 0);
      fetch_en = 0; rom_valid = 1; rom_data = 32'h2129_0004; step();
      rom_valid = 0;
      check("t2_instr_valid", {31'd0, instr_valid}, 1);
      check("t2_instr_out", instr_out, 32'h2129_0004);
      check("t2_pc_out", pc_out, BASE);
      check("t2_pc_plus4", pc_plus4, BASE + 4);
      check("t2_next_addr", {24'd0, rom_addr}, 1);
      // T3 decode stall, then accept with fetch_en
      repeat (3) step();
      check("t3_instr_valid", {31'd0, instr_valid}, 1);
      check("t3_instr_out", instr_out, 32'h2129_0004);
      check("t3_rom_req", {31'd0, rom_req}, 0);
      instr_ready = 1; fetch_en = 1; step();
      instr_ready = 0; fetch_en = 0;
      check("t3_rom_req_next", {31'd0, rom_req}, 1);
      check("t3_rom_addr", {24'd0, rom_addr}, 1);
      check("t3_instr_valid_drop", {31'd0, instr_valid}, 0);
      // T4 redirect collides with returning word
      redirect = 1; redirect_pc = BASE + 32'h20; rom_valid = 1; rom_data = 32'hDEAD_BEEF; step();
      redirect = 0; rom_valid = 0;
      check("t4_instr_out", instr_out, 32'h2129_0004);
      check("t4_rom_req", {31'd0, rom_req}, 1);
      check("t4_rom_addr", {24'd0, rom_addr}, 8);
      check("t4_align_err", {31'd0, align_err}, 0);
      check("t4_instr_valid", {31'd0, instr_valid}, 0);
      // T5 misaligned redirect, then out-of-window redirect
      redirect = 1; redirect_pc = BASE + 32'h22; step();
      redirect = 0;
      check("t5_align_err", {31'd0, align_err}, 1);
      check("t5_rom_addr", {24'd0, rom_addr}, 8);
      step();
      check("t5_align_pulse", {31'd0, align_err}, 0);
      redirect = 1; redirect_pc = BASE + 32'h400; step();
      redirect = 0;
      check("t5_range_err", {31'd0, range_err}, 1);
      check("t5_range_rom_req", {31'd0, rom_req}, 1);
      // T6 reset mid-fetch, late rom_valid ignored
      reset = 1; step();
      reset = 0;
      check("t6_rom_req", {31'd0, rom_req}, 0);
      check("t6_instr_out", instr_out, 0);
      check("t6_pc_out", pc_out, BASE);
      rom_valid = 1; rom_data = 32'h1234_5678; step();
      rom_valid = 0;
      check("t6_late_valid", {31'd0, instr_valid}, 0);
      check("t6_late_instr", instr_out, 0);
      check("t6_late_req", {31'd0, rom_req}, 0);
      // Randomized traffic: the model tracks the next fetch address and the words owed to decode.
      model_pc = BASE;
      mon_on = 1;
      for (int n = 0; n < 3000; n++) begin
         step();
         rq = rom_req;
         if (n >= 2990) begin
            fetch_en = 0; instr_ready = 1; redirect = 0; rom_valid = 1;
         end else begin
            fetch_en = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) != 0;
            redirect = ($urandom % 12) == 0;
            rom_valid = $urandom % 2;
            r = $urandom % 8;
            redirect_pc = (r == 0) ? BASE + $urandom_range(0, 1023) :
                          (r == 1) ? BASE + 32'h400 + ($urandom_range(0, 63) << 2) :
                          (r == 2) ? BASE - 32'd16 :
                                     BASE + ($urandom_range(0, DEPTH - 1) << 2);
         end
         rom_data = rom_mem[rom_addr];
         off = model_pc - BASE;
         if (rq) addr_q.push_back('{a: 8'(off / 4 % DEPTH), r: (off / 4) >= DEPTH});
         if (redirect) model_pc = redirect_pc & ~32'd3;
         else if (rq && rom_valid) begin
            exp_q.push_back('{instr: rom_mem[off / 4 % DEPTH], pc: model_pc});
            model_pc = model_pc + 4;
         end
      end
      rom_valid = 0;
      repeat (3) step();
      @(negedge clk);
      #1;
      mon_on = 0;
      check("drain_exp_q", exp_q.size(), 0);
      check("drain_addr_q", addr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
